// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse_meter block: FSM state encoding,
// default synchronizer depth and the counter saturation value.
`timescale 1ns/1ps
package pulse_meter_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_WAIT = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } state_t;

  // All-ones value of a counter 'width' bits wide (the saturation limit).
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/pulse_meter_if.sv
// Measurement bus of pulse_meter: the sampled pulse train in, one
// high/low/overflow result per complete period out.
`timescale 1ns/1ps
interface pulse_meter_if #(
  parameter int WIDTH = 8
);
  logic             signal;
  logic [WIDTH-1:0] high_count;
  logic [WIDTH-1:0] low_count;
  logic             valid;
  logic             overflow;

  modport master (
    input  signal,
    output high_count, low_count, valid, overflow
  );

  modport slave (
    output signal,
    input  high_count, low_count, valid, overflow
  );
endinterface

// File: rtl/pulse_meter_edge_sync.sv
// edge_sync: synchronizes an asynchronous level, optionally filters 1-cycle
// glitches (PULSE_METER_DEGLITCH_EN) and produces rise/fall strobes.
`timescale 1ns/1ps
module edge_sync
  import pulse_meter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

`ifdef PULSE_METER_DEGLITCH_EN
  localparam int PRIME_LEN = SYNC_STAGES + 2;
`else
  localparam int PRIME_LEN = SYNC_STAGES + 1;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic [PRIME_LEN-1:0]   prime_q;
  logic                   s;
  logic                   s_d_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // NOTE: registers are written with <= so every flop samples the pre-edge
  // value of its neighbours; a blocking '=' here would collapse the chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      s_d_q   <= 1'b0;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      s_d_q   <= s;
      prime_q <= {prime_q[PRIME_LEN-2:0], 1'b1};
    end
  end

`ifdef PULSE_METER_DEGLITCH_EN
  logic sync_d_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_d_q <= 1'b0;
    else       sync_d_q <= sync_out;
  end

  // Accept a new level only once it has been seen on two consecutive cycles.
  assign s = (sync_out == sync_d_q) ? sync_out : s_d_q;
`else
  assign s = sync_out;
`endif

  // Edges are masked until the pipeline holds real samples, so an input
  // already high at reset release is not mistaken for a rising edge.
  assign level = s;
  assign rise  = s & ~s_d_q & prime_q[PRIME_LEN-1];
  assign fall  = ~s & s_d_q & prime_q[PRIME_LEN-1];

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures high and low time of each complete period of an
// asynchronous pulse train. Build option PULSE_METER_DEGLITCH_EN adds a glitch filter.
`timescale 1ns/1ps
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input logic           clock,
  input logic           reset,
  pulse_meter_if.master bus
);

  localparam logic [WIDTH-1:0] SAT = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic level, rise, fall;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (bus.signal),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] lcnt_q, lcnt_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             new_period;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == SAT) ? v : v + ONE;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      high_q  <= '0;
      low_q   <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      high_q  <= high_d;
      low_q   <= low_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    lcnt_d     = lcnt_q;
    high_d     = high_q;
    low_d      = low_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    new_period = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        if (rise) begin
          new_period = 1'b1;
          state_d    = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          lcnt_d  = ONE;
          state_d = ST_LOW;
        end else if (level) begin
          hcnt_d = sat_inc(hcnt_q);
        end
      end
      ST_LOW: begin
        if (rise) begin
          high_d     = hcnt_q;
          low_d      = lcnt_q;
          ovf_d      = sat_q;
          valid_d    = 1'b1;
          new_period = 1'b1;
          state_d    = ST_HIGH;
        end else if (!level) begin
          lcnt_d = sat_inc(lcnt_q);
        end
      end
      default: state_d = ST_WAIT;
    endcase

    if (new_period) begin
      hcnt_d = ONE;
      lcnt_d = '0;
    end

    // Sticky saturation flag, restarted with every new period.
    sat_d = (new_period ? 1'b0 : sat_q) | (hcnt_d == SAT) | (lcnt_d == SAT);
  end

  assign bus.high_count = high_q;
  assign bus.low_count  = low_q;
  assign bus.valid      = valid_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter: directed pulse trains push expected
// measurements; a monitor pops and compares on every valid strobe.
`timescale 1ns/1ps
module tb_pulse_meter;
  import pulse_meter_pkg::*;

  localparam int WIDTH = 8;
  localparam int SYNC  = SYNC_STAGES_DEFAULT;
`ifdef PULSE_METER_DEGLITCH_EN
  localparam int LAT  = SYNC + 2;
  localparam int FAST = 2;
`else
  localparam int LAT  = SYNC + 1;
  localparam int FAST = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pulse_meter_if #(.WIDTH(WIDTH)) bus ();

  pulse_meter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ovf;
  } meas_t;

  meas_t exp_q[$];
  int    vtimes[$];
  int    cyc   = 0;
  int    total = 0;
  int    bad   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic meas_t mk(input int h, input int l, input bit o);
    meas_t m;
    m.hi  = WIDTH'(h);
    m.lo  = WIDTH'(l);
    m.ovf = o;
    return m;
  endfunction

  // Monitor: every valid strobe must match the oldest expected measurement.
  always @(negedge clock) begin
    if (bus.valid === 1'b1) begin
      meas_t e;
      vtimes.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected valid: got high=%0d low=%0d ovf=%0d, required no strobe (t=%0t)",
                 bus.high_count, bus.low_count, bus.overflow, $time);
      end else begin
        e = exp_q.pop_front();
        check("high_count", bus.high_count, e.hi);
        check("low_count",  bus.low_count,  e.lo);
        check("overflow",   bus.overflow,   e.ovf);
      end
    end
  end

  task automatic hold(input logic lvl, input int n);
    bus.signal = lvl;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    bus.signal = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    vtimes.delete();
    repeat (4) @(negedge clock);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clock);
    check({name, " pending"}, exp_q.size(), 0);
  endtask

  task automatic check_spacing(input string name, input int n, input int gap);
    check({name, " strobes"}, vtimes.size(), n);
    for (int i = 1; i < vtimes.size(); i++)
      check({name, " spacing"}, vtimes[i] - vtimes[i-1], gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  found;
    bus.signal = 1'b0;

    // Reset state.
    #12;
    check("reset high_count", bus.high_count, 0);
    check("reset low_count",  bus.low_count,  0);
    check("reset valid",      bus.valid,      0);
    check("reset overflow",   bus.overflow,   0);

    // Steady 4 high / 8 low train, 5 periods: first discarded.
    do_reset();
    repeat (4) exp_q.push_back(mk(4, 8, 0));
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 4);
      hold(1'b0, 8);
    end
    hold(1'b0, 4);
    drain("steady");
    check_spacing("steady", 4, 12);

    // Fastest measurable toggle.
    do_reset();
    repeat (5) exp_q.push_back(mk(FAST, FAST, 0));
    for (int i = 0; i < 6; i++) begin
      hold(1'b1, FAST);
      hold(1'b0, FAST);
    end
    hold(1'b0, 6);
    drain("toggle");
    check_spacing("toggle", 5, 2 * FAST);

    // Saturating high phase, then a normal period clears overflow.
    do_reset();
    exp_q.push_back(mk(255, 10, 1));
    exp_q.push_back(mk(5, 5, 0));
    hold(1'b1, 300);
    hold(1'b0, 10);
    hold(1'b1, 5);
    hold(1'b0, 5);
    hold(1'b1, 2);
    hold(1'b0, 6);
    drain("saturation");

    // Asynchronous reset in the middle of a high phase.
    do_reset();
    exp_q.push_back(mk(4, 4, 0));
    hold(1'b1, 4);
    hold(1'b0, 4);
    hold(1'b1, 5);
    check("pre-reset high_count", bus.high_count, 4);
    #3 reset = 1'b1;
    #1;
    check("async reset high_count", bus.high_count, 0);
    check("async reset low_count",  bus.low_count,  0);
    check("async reset valid",      bus.valid,      0);
    check("async reset overflow",   bus.overflow,   0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    vtimes.delete();
    exp_q.push_back(mk(3, 7, 0));
    hold(1'b1, 6);
    hold(1'b0, 4);
    hold(1'b1, 3);
    hold(1'b0, 7);
    hold(1'b1, 2);
    hold(1'b0, 8);
    drain("reset restart");
    check("reset restart strobes", vtimes.size(), 1);

    // Latency from raw rise to valid.
    do_reset();
    exp_q.push_back(mk(4, 8, 0));
    hold(1'b1, 4);
    hold(1'b0, 8);
    bus.signal = 1'b1;
    lat   = 0;
    found = 1'b0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(posedge clock);
      #1;
      if (bus.valid === 1'b1) begin
        found = 1'b1;
        lat   = k;
      end
    end
    check("latency edges", lat, LAT);
    @(negedge clock);
    hold(1'b1, 2);
    hold(1'b0, 5);
    drain("latency");

    // One-cycle low glitch inside a 10-cycle high phase.
    do_reset();
`ifdef PULSE_METER_DEGLITCH_EN
    exp_q.push_back(mk(10, 6, 0));
`else
    exp_q.push_back(mk(4, 1, 0));
    exp_q.push_back(mk(5, 6, 0));
`endif
    hold(1'b1, 4);
    hold(1'b0, 1);
    hold(1'b1, 5);
    hold(1'b0, 6);
    hold(1'b1, 3);
    hold(1'b0, 6);
    drain("glitch");
`ifdef PULSE_METER_DEGLITCH_EN
    check("glitch strobes", vtimes.size(), 1);
`else
    check("glitch strobes", vtimes.size(), 2);
`endif

    repeat (4) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Receive-side counterpart of the team's clocked pulse generator.
- Samples an asynchronous pulse train on `signal`, then measures each complete period as a high-time and a low-time, in clock cycles.
- Publishes each measurement with a one-cycle `valid` strobe.
- Used in benches and on-chip to check generated waveforms against expected duty and period.

Parameters:
- WIDTH, 8, bit width of the high/low counters and their outputs.
- SYNC_STAGES, 2, number of synchronizer flops on `signal` (minimum 2).

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clears all state.
- signal  input  1  pulse train to measure; asynchronous to `clock`.
- high_count  output  WIDTH  clock cycles `signal` was high in the last complete period.
- low_count  output  WIDTH  clock cycles `signal` was low in the last complete period.
- valid  output  1  one-cycle strobe; `high_count`, `low_count` and `overflow` were updated this cycle.
- overflow  output  1  last published measurement saturated in either counter.

Behaviour:
- One clock; reset is asynchronous and active-high; ports named `clock` and `reset`.
- Reset values:
  - all synchronizer flops 0
  - state WAIT
  - internal hcnt/lcnt 0
  - `high_count`, `low_count`, `valid`, `overflow` all 0
- Synchronizer and edge detect:
  - `signal` passes through SYNC_STAGES flops, giving `s`.
  - `s_d` is `s` delayed by one cycle.
  - rise = `s` & ~`s_d`; fall = ~`s` & `s_d`.
- FSM states: WAIT, HIGH, LOW. Transitions:
  - WAIT: ignore everything until rise, then go HIGH with hcnt=1. This discards the partial pulse after reset.
  - HIGH: while `s`=1, hcnt+1 each cycle. On fall, go LOW with lcnt=1.
  - LOW: while `s`=0, lcnt+1 each cycle. On rise, do all of the following in the same edge:
    - publish `high_count`=hcnt, `low_count`=lcnt
    - set `overflow` = hcnt or lcnt saturated
    - pulse `valid`=1
    - set hcnt=1 and go HIGH
- Counter arithmetic: unsigned, saturating at 2^WIDTH-1, never wrapping. A saturated counter sets an internal sticky flag, cleared when the new period starts.
- `valid` is high for exactly one cycle per complete period; it is never asserted from WAIT.
- Outputs hold their value between `valid` strobes.
- Latency: `valid` rises SYNC_STAGES+1 clock edges after the raw rising edge of `signal` (first edge at which `signal` is sampled high).
- Minimum measurable period is 2 cycles (1 high, 1 low), which produces `valid` every 2 cycles.
- Reset mid-operation: any partial measurement is lost; behaviour restarts exactly as after power-up.
- `signal` high at reset release: the block stays in WAIT until a fall then rise has occurred, so the first `valid` follows the first full period.

Optional Feature:
- Macro: PULSE_METER_DEGLITCH_EN.
- Defined:
  - A 2-sample stability filter sits after the synchronizer. `s` changes only after the synchronized input holds a new level for 2 consecutive cycles.
  - Single-cycle glitches are ignored and counted as part of the surrounding level.
  - Latency to `valid` becomes SYNC_STAGES+2.
  - Minimum measurable period is 4 cycles.
- Undefined: no filter; every synchronized transition is an edge; latency as above.

Decomposition:
- Shared package pulse_meter_pkg holds:
  - state typedef (WAIT, HIGH, LOW) with fixed 2-bit encoding
  - saturation constant helper (all-ones of WIDTH)
  - SYNC_STAGES default
- One natural sub-module, edge_sync:
  - contents: synchronizer chain, optional deglitch filter, rise/fall detect
  - parameter: SYNC_STAGES
  - ports: `clock`, `reset`, async_in, level, rise, fall
- pulse_meter instantiates edge_sync and holds the FSM, the counters and the output registers.

Test Plan:
- Steady train, 4 cycles high / 8 cycles low, repeated 5 times → 4 `valid` strobes spaced 12 cycles apart, each with `high_count`=4, `low_count`=8, `overflow`=0. The first period is discarded.
- Fastest toggle, `signal` inverted every cycle → `valid` every 2 cycles with `high_count`=1, `low_count`=1.
- Saturation, WIDTH=8, `signal` high 300 cycles then low 10 cycles then rise → `high_count`=255, `low_count`=10, `overflow`=1. Next normal 5/5 period → `overflow`=0.
- Reset mid-HIGH:
  - stimulus: assert `reset` asynchronously (not on a clock edge) during a high phase.
  - required: all outputs read 0 immediately, with no `valid`.
  - after release, the first `valid` appears only after one full discarded-then-measured period, with correct counts.
- Latency check: raw `signal` rise at the end of the LOW phase → `valid` seen exactly SYNC_STAGES+1 clock edges later (3 with defaults).
- With PULSE_METER_DEGLITCH_EN, a 1-cycle low glitch inside a 10-cycle high, then 6 low cycles → single `valid`, `high_count`=10, `low_count`=6. Without the macro, the same stimulus splits into extra periods.
